// File: rtl/led_sequencer.sv
// led_sequencer: parametrised LED pattern engine (rotate left/right, bounce, binary count).
//   A prescaler produces a step every TICK_CYCLES >> speed clocks while running. While paused,
//   single-step pulses advance the pattern. The tick output pulses in the cycle a new pattern first shows.
// Ports: sys_clk/sys_rst_n (async active-low); mode[1:0], speed[1:0], run, step in;
//   led[N_LED-1:0] (polarity set by ACTIVE_LOW), tick out. Latency: pattern and tick are registered.
module led_sequencer #(
   parameter int N_LED       = 6,
   parameter int TICK_CYCLES = 13_500_000,
   parameter bit ACTIVE_LOW  = 1'b1
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic [1:0]       mode,
   input  logic [1:0]       speed,
   input  logic             run,
   input  logic             step,
   output logic [N_LED-1:0] led,
   output logic             tick
);

   localparam int CW = $clog2(TICK_CYCLES);

   typedef enum logic [1:0] {
      ROT_L  = 2'd0,
      ROT_R  = 2'd1,
      BOUNCE = 2'd2,
      COUNT  = 2'd3
   } mode_t;

   logic [CW-1:0]    cnt, cnt_nxt, period_m1;
   logic [N_LED-1:0] pat, pat_nxt, pat_adv, rot_l, rot_r;
   logic             dir, dir_nxt, dir_adv;   // dir=1: lit bit moving towards MSB
   logic [1:0]       mode_q, speed_q;
   logic             tick_nxt;
   logic             advance;
   logic             mode_chg;
   mode_t            cur_mode;

   assign cur_mode = mode_t'(mode_q);
   assign mode_chg = (mode != mode_q);

   // Period compare uses the registered speed; cnt is never cleared on a speed change,
   // so ">=" lets an over-range count fire on the next edge instead of wrapping.
   assign period_m1 = CW'((TICK_CYCLES >> speed_q) - 1);
   assign advance   = run ? (cnt >= period_m1) : step;

   // Rotations written as index maps so N_LED=1 degenerates to a hold.
   always_comb begin
      rot_l = '0;
      rot_r = '0;
      for (int i = 0; i < N_LED; i++) begin
         rot_l[i] = pat[(i + N_LED - 1) % N_LED];
         rot_r[i] = pat[(i + 1) % N_LED];
      end
   end

   // Next pattern for one step in the current mode.
   always_comb begin
      pat_adv = pat;
      dir_adv = dir;
      case (cur_mode)
         ROT_L:  pat_adv = rot_l;
         ROT_R:  pat_adv = rot_r;
         BOUNCE: begin
            if (N_LED > 1) begin
               // Direction flips and the bit moves inward in the same step,
               // so the end positions are never shown twice in a row.
               if (dir) begin
                  if (pat[N_LED-1]) begin
                     pat_adv = pat >> 1;
                     dir_adv = 1'b0;
                  end else begin
                     pat_adv = pat << 1;
                  end
               end else begin
                  if (pat[0]) begin
                     pat_adv = pat << 1;
                     dir_adv = 1'b1;
                  end else begin
                     pat_adv = pat >> 1;
                  end
               end
            end
         end
         COUNT:  pat_adv = pat + N_LED'(1);
         default: pat_adv = pat;
      endcase
   end

   // Mode change outranks a coinciding advance: reload, restart the period, no tick.
   always_comb begin
      pat_nxt  = pat;
      dir_nxt  = dir;
      cnt_nxt  = cnt;
      tick_nxt = 1'b0;
      if (mode_chg) begin
         pat_nxt = (mode == COUNT) ? '0 : N_LED'(1);
         dir_nxt = 1'b1;
         cnt_nxt = '0;
      end else begin
         if (!run)
            cnt_nxt = '0;
         else if (advance)
            cnt_nxt = '0;
         else
            cnt_nxt = cnt + CW'(1);
         if (advance) begin
            pat_nxt  = pat_adv;
            dir_nxt  = dir_adv;
            tick_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt     <= '0;
         pat     <= N_LED'(1);
         dir     <= 1'b1;
         mode_q  <= 2'd0;
         speed_q <= 2'd0;
         tick    <= 1'b0;
      end else begin
         cnt     <= cnt_nxt;
         pat     <= pat_nxt;
         dir     <= dir_nxt;
         mode_q  <= mode;
         speed_q <= speed;
         tick    <= tick_nxt;
      end
   end

   assign led = ACTIVE_LOW ? ~pat : pat;

endmodule
